// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction-time game controller.
package reaction_pkg;

    // Round state of the controller
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        COUNTDOWN = 3'd2,
        TIMING    = 3'd3,
        RESULT    = 3'd4
    } state_t;

    // Defaults: 100 MHz clock -> 1 ms tick, timeout just under 10 s
    localparam int TICK_DIV_DEF = 100000;
    localparam int MAX_MS_DEF   = 9999;
    localparam int MS_W_DEF     = 14;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// on the terminal count, wrapping to 0 in the same cycle.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    // Prescaler count; clr restarts a fresh millisecond
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game round controller. Starts the external countdown block,
// measures milliseconds from countdown completion to the react button, and
// flags false starts and timeouts. Result is held until the next btn_go.
// Optional macro REACTION_BEST_TIME_EN adds best_ms/best_valid tracking of
// the fastest valid round since reset.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int MAX_MS   = MAX_MS_DEF,
    parameter int MS_W     = MS_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_go,
    input  logic            btn_react,
    input  logic            countdown_in_action,
    input  logic            countdown_done,
    output logic            countdown_start,
    output logic            busy,
    output logic            result_valid,
    output logic            false_start,
    output logic            timeout,
    output logic [MS_W-1:0] reaction_ms
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [MS_W-1:0] best_ms,
    output logic            best_valid
`endif
);

    state_t          state, state_next;
    logic [MS_W-1:0] ms_cnt, ms_cnt_next;
    logic [MS_W-1:0] reaction_next;
    logic            start_next, fs_next, to_next;
    logic            presc_clr, presc_en, tick;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Next-state and next-output decode
    always_comb begin
        state_next    = state;
        ms_cnt_next   = ms_cnt;
        reaction_next = reaction_ms;
        start_next    = countdown_start;
        fs_next       = false_start;
        to_next       = timeout;
        presc_clr     = 1'b0;
        presc_en      = 1'b0;
        case (state)
            IDLE: begin
                start_next = 1'b0;
                if (btn_go) begin
                    state_next = ARM;
                    start_next = 1'b1;
                end
            end
            ARM: begin
                // Countdown block is on a slower clock: hold start as a level
                start_next = 1'b1;
                if (btn_react) begin
                    state_next    = RESULT;
                    start_next    = 1'b0;
                    fs_next       = 1'b1;
                    reaction_next = '0;
                end else if (countdown_in_action) begin
                    state_next = COUNTDOWN;
                    start_next = 1'b0;
                end
            end
            COUNTDOWN: begin
                start_next = 1'b0;
                if (btn_react) begin
                    state_next    = RESULT;
                    fs_next       = 1'b1;
                    reaction_next = '0;
                end else if (countdown_done && !countdown_in_action) begin
                    state_next  = TIMING;
                    presc_clr   = 1'b1;
                    ms_cnt_next = '0;
                end
            end
            TIMING: begin
                presc_en = 1'b1;
                if (tick) begin
                    ms_cnt_next = ms_cnt + MS_W'(1);
                end
                // Press beats a same-cycle tick, including the timeout tick
                if (btn_react) begin
                    state_next    = RESULT;
                    reaction_next = ms_cnt;
                    fs_next       = 1'b0;
                    to_next       = 1'b0;
                end else if (tick && (ms_cnt == MS_W'(MAX_MS - 1))) begin
                    state_next    = RESULT;
                    reaction_next = MS_W'(MAX_MS);
                    to_next       = 1'b1;
                end
            end
            RESULT: begin
                if (btn_go) begin
                    state_next    = ARM;
                    start_next    = 1'b1;
                    reaction_next = '0;
                    fs_next       = 1'b0;
                    to_next       = 1'b0;
                end
            end
            default: begin
                state_next    = IDLE;
                start_next    = 1'b0;
                reaction_next = '0;
                fs_next       = 1'b0;
                to_next       = 1'b0;
                ms_cnt_next   = '0;
            end
        endcase
    end

    // State, ms counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ms_cnt          <= '0;
            countdown_start <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            false_start     <= 1'b0;
            timeout         <= 1'b0;
            reaction_ms     <= '0;
        end else begin
            state           <= state_next;
            ms_cnt          <= ms_cnt_next;
            countdown_start <= start_next;
            busy            <= (state_next == ARM) || (state_next == COUNTDOWN) ||
                               (state_next == TIMING);
            result_valid    <= (state_next == RESULT);
            false_start     <= fs_next;
            timeout         <= to_next;
            reaction_ms     <= reaction_next;
        end
    end

`ifdef REACTION_BEST_TIME_EN
    // Best-time tracker: only a press in TIMING yields a clean result
    always_ff @(posedge clk) begin
        if (rst) begin
            best_ms    <= '0;
            best_valid <= 1'b0;
        end else if ((state == TIMING) && btn_react) begin
            best_valid <= 1'b1;
            if (!best_valid || (ms_cnt < best_ms)) begin
                best_ms <= ms_cnt;
            end
        end
    end
`endif

endmodule
